// File: rtl/vreg_status_file_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : vreg_status_file_pkg                                     |
// | Description : Shared sizing constants and types for the virtual        |
// |               register status file. The writeback merger and the       |
// |               reservation stations import the same package.            |
// |   VREG_NUM  : number of virtual registers (power of two)               |
// |   VREG_W    : vregid width, log2(VREG_NUM)                             |
// |   XLEN      : data width                                               |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package vreg_status_file_pkg;

    localparam int VREG_NUM = 32;
    localparam int VREG_W   = 5;
    localparam int XLEN     = 32;

    typedef logic [VREG_W-1:0] vreg_id_t;
    typedef logic [XLEN-1:0]   xlen_t;

endpackage : vreg_status_file_pkg
`default_nettype wire

// File: rtl/vreg_query_port.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : vreg_query_port                                          |
// | Description : One operand query port. Reads the ready bit and value    |
// |               of q_vregid from the stored arrays, combinationally.     |
// |               With VREG_STATUS_FILE_FORWARD_EN defined, an accepted    |
// |               same-cycle writeback to the queried id is bypassed.      |
// | Ports       : ready_arr_i / val_arr_i  - stored state                  |
// |               q_vregid_i               - queried index                 |
// |               fwd_en_i/fwd_vregid_i/fwd_val_i - bypass (macro only)    |
// |               q_ready_o / q_val_o      - query result                  |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module vreg_query_port
    import vreg_status_file_pkg::*;
(
    input  logic [VREG_NUM-1:0]        ready_arr_i,
    input  xlen_t [VREG_NUM-1:0]       val_arr_i,
    input  vreg_id_t                   q_vregid_i,
`ifdef VREG_STATUS_FILE_FORWARD_EN
    input  logic                       fwd_en_i,
    input  vreg_id_t                   fwd_vregid_i,
    input  xlen_t                      fwd_val_i,
`endif
    output logic                       q_ready_o,
    output xlen_t                      q_val_o
);

`ifdef VREG_STATUS_FILE_FORWARD_EN
    always_comb begin
        q_ready_o = ready_arr_i[q_vregid_i];
        q_val_o   = val_arr_i[q_vregid_i];
        // Writeback landing this cycle wins over the stored copy.
        if (fwd_en_i && (fwd_vregid_i == q_vregid_i)) begin
            q_ready_o = 1'b1;
            q_val_o   = fwd_val_i;
        end
    end
`else
    always_comb begin
        q_ready_o = ready_arr_i[q_vregid_i];
        q_val_o   = val_arr_i[q_vregid_i];
    end
`endif

endmodule : vreg_query_port
`default_nettype wire

// File: rtl/vreg_status_file.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : vreg_status_file                                         |
// | Description : Per-virtual-register ready bit and value store. Rename   |
// |               marks entries busy (alloc), the serialized writeback     |
// |               stream marks them ready and stores the value, flush      |
// |               makes every entry ready. Two combinational query ports   |
// |               serve the reservation stations; busy_cnt/full give       |
// |               rename back-pressure.                                    |
// | Ports       : clk, rst (sync, active-high), hci_rdy (global enable),   |
// |               flush, alloc_en/alloc_vregid, wb_en/wb_vregid/wb_val,    |
// |               q1_*/q2_* query ports, busy_cnt, full.                   |
// | Option      : VREG_STATUS_FILE_FORWARD_EN - same-cycle writeback       |
// |               bypass on the query ports.                               |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module vreg_status_file
    import vreg_status_file_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            hci_rdy,
    input  logic            flush,
    input  logic            alloc_en,
    input  vreg_id_t        alloc_vregid,
    input  logic            wb_en,
    input  vreg_id_t        wb_vregid,
    input  xlen_t           wb_val,
    input  vreg_id_t        q1_vregid,
    output logic            q1_ready,
    output xlen_t           q1_val,
    input  vreg_id_t        q2_vregid,
    output logic            q2_ready,
    output xlen_t           q2_val,
    output logic [VREG_W:0] busy_cnt,
    output logic            full
);

    localparam logic [VREG_W:0] c_CNT_MAX = (VREG_W+1)'(VREG_NUM);

    logic [VREG_NUM-1:0]  ready_q, ready_d;
    xlen_t [VREG_NUM-1:0] val_q, val_d;
    logic [VREG_W:0]      busy_cnt_q, busy_cnt_d;
    logic                 full_q, full_d;
    logic                 w_inc, w_dec;

    always_comb begin
        ready_d    = ready_q;
        val_d      = val_q;
        busy_cnt_d = busy_cnt_q;
        w_inc      = 1'b0;
        w_dec      = 1'b0;
        if (flush) begin
            ready_d    = '1;
            busy_cnt_d = '0;
        end else begin
            w_inc = alloc_en && ready_q[alloc_vregid];
            // A writeback to the id being allocated this cycle leaves the
            // entry busy, so it must not release a busy slot.
            w_dec = wb_en && !ready_q[wb_vregid]
                    && !(alloc_en && (alloc_vregid == wb_vregid));
            if (wb_en) begin
                ready_d[wb_vregid] = 1'b1;
                val_d[wb_vregid]   = wb_val;
            end
            // Applied after the writeback so alloc wins on a collision.
            if (alloc_en) begin
                ready_d[alloc_vregid] = 1'b0;
            end
            if (w_inc && !w_dec && (busy_cnt_q != c_CNT_MAX)) begin
                busy_cnt_d = busy_cnt_q + 1'b1;
            end else if (w_dec && !w_inc && (busy_cnt_q != '0)) begin
                busy_cnt_d = busy_cnt_q - 1'b1;
            end
        end
        full_d = (busy_cnt_d == c_CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q    <= '1;
            val_q      <= '0;
            busy_cnt_q <= '0;
            full_q     <= 1'b0;
        end else if (hci_rdy) begin
            ready_q    <= ready_d;
            val_q      <= val_d;
            busy_cnt_q <= busy_cnt_d;
            full_q     <= full_d;
        end
    end

    assign busy_cnt = busy_cnt_q;
    assign full     = full_q;

`ifdef VREG_STATUS_FILE_FORWARD_EN
    logic w_fwd_en;
    assign w_fwd_en = wb_en && hci_rdy && !flush && !rst;
`endif

    vreg_query_port u_q1 (
        .ready_arr_i  (ready_q),
        .val_arr_i    (val_q),
        .q_vregid_i   (q1_vregid),
`ifdef VREG_STATUS_FILE_FORWARD_EN
        .fwd_en_i     (w_fwd_en),
        .fwd_vregid_i (wb_vregid),
        .fwd_val_i    (wb_val),
`endif
        .q_ready_o    (q1_ready),
        .q_val_o      (q1_val)
    );

    vreg_query_port u_q2 (
        .ready_arr_i  (ready_q),
        .val_arr_i    (val_q),
        .q_vregid_i   (q2_vregid),
`ifdef VREG_STATUS_FILE_FORWARD_EN
        .fwd_en_i     (w_fwd_en),
        .fwd_vregid_i (wb_vregid),
        .fwd_val_i    (wb_val),
`endif
        .q_ready_o    (q2_ready),
        .q_val_o      (q2_val)
    );

endmodule : vreg_status_file
`default_nettype wire

// File: tb/tb_vreg_status_file.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_vreg_status_file                                      |
// | Description : Self-checking bench for vreg_status_file. A reference    |
// |               model holds ready/value arrays and derives the busy      |
// |               count as the number of not-ready entries.                |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_vreg_status_file;

    logic        clk = 1'b0;
    logic        rst, hci_rdy, flush, alloc_en, wb_en;
    logic [4:0]  alloc_vregid, wb_vregid, q1_vregid, q2_vregid;
    logic [31:0] wb_val;
    logic        q1_ready, q2_ready, full;
    logic [31:0] q1_val, q2_val;
    logic [5:0]  busy_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_ready [32];
    logic [31:0] m_val   [32];
    bit          live = 1'b0;

    always #5 clk = ~clk;

    vreg_status_file dut (
        .clk          (clk),
        .rst          (rst),
        .hci_rdy      (hci_rdy),
        .flush        (flush),
        .alloc_en     (alloc_en),
        .alloc_vregid (alloc_vregid),
        .wb_en        (wb_en),
        .wb_vregid    (wb_vregid),
        .wb_val       (wb_val),
        .q1_vregid    (q1_vregid),
        .q1_ready     (q1_ready),
        .q1_val       (q1_val),
        .q2_vregid    (q2_vregid),
        .q2_ready     (q2_ready),
        .q2_val       (q2_val),
        .busy_cnt     (busy_cnt),
        .full         (full)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_busy();
        int n = 0;
        for (int i = 0; i < 32; i++) if (!m_ready[i]) n++;
        return n;
    endfunction

    // Expected query result for the current (pre-edge) cycle.
    function automatic logic [32:0] model_query(input logic [4:0] q);
        logic [32:0] r;
        r = {m_ready[q], m_val[q]};
`ifdef VREG_STATUS_FILE_FORWARD_EN
        if (wb_en && hci_rdy && !flush && !rst && (wb_vregid == q)) r = {1'b1, wb_val};
`endif
        return r;
    endfunction

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < 32; i++) begin m_ready[i] = 1'b1; m_val[i] = '0; end
        end else if (hci_rdy) begin
            if (flush) begin
                for (int i = 0; i < 32; i++) m_ready[i] = 1'b1;
            end else begin
                if (wb_en) begin m_ready[wb_vregid] = 1'b1; m_val[wb_vregid] = wb_val; end
                if (alloc_en) m_ready[alloc_vregid] = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive, check queries before the edge, update model,
    // then check the registered outputs just after the edge.
    task automatic cyc(input bit r, input bit h, input bit f,
                       input bit ae, input logic [4:0] aid,
                       input bit we, input logic [4:0] wid, input logic [31:0] wv,
                       input logic [4:0] qa, input logic [4:0] qb);
        logic [32:0] e1, e2;
        rst = r; hci_rdy = h; flush = f;
        alloc_en = ae; alloc_vregid = aid;
        wb_en = we; wb_vregid = wid; wb_val = wv;
        q1_vregid = qa; q2_vregid = qb;
        #2;
        if (live) begin
            e1 = model_query(qa);
            e2 = model_query(qb);
            chk("q1_ready", 64'(q1_ready), 64'(e1[32]));
            chk("q1_val",   64'(q1_val),   64'(e1[31:0]));
            chk("q2_ready", 64'(q2_ready), 64'(e2[32]));
            chk("q2_val",   64'(q2_val),   64'(e2[31:0]));
        end
        @(posedge clk);
        model_edge();
        if (r) live = 1'b1;
        #1;
        if (live) begin
            chk("busy_cnt", 64'(busy_cnt), 64'(model_busy()));
            chk("full",     64'(full),     64'(model_busy() == 32));
        end
    endtask

    task automatic idle(input logic [4:0] qa, input logic [4:0] qb);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, qa, qb);
    endtask

    initial begin
        rst = 1'b1; hci_rdy = 1'b0; flush = 1'b0; alloc_en = 1'b0; wb_en = 1'b0;
        alloc_vregid = '0; wb_vregid = '0; wb_val = '0; q1_vregid = '0; q2_vregid = '0;
        @(posedge clk); #1;

        // Reset overrides hci_rdy = 0.
        cyc(1, 0, 0, 1, 2, 1, 3, 32'h77, 0, 31);
        idle(0, 31);
        chk("rst_q1_ready", 64'(q1_ready), 64'd1);
        chk("rst_q2_val",   64'(q2_val),   64'd0);
        chk("rst_busy",     64'(busy_cnt), 64'd0);

        // Alloc 7, then writeback 7.
        cyc(0, 1, 0, 1, 7, 0, 0, 0, 7, 7);
        idle(7, 0);
        chk("alloc7_ready", 64'(q1_ready), 64'd0);
        chk("alloc7_busy",  64'(busy_cnt), 64'd1);
        cyc(0, 1, 0, 0, 0, 1, 7, 32'hDEADBEEF, 7, 7);
        idle(7, 0);
        chk("wb7_val",  64'(q1_val),   64'hDEADBEEF);
        chk("wb7_busy", 64'(busy_cnt), 64'd0);

        // Alloc and writeback to id 3 in the same cycle.
        cyc(0, 1, 0, 1, 3, 1, 3, 32'h55, 3, 3);
        idle(3, 3);
        chk("col3_ready", 64'(q1_ready), 64'd0);
        chk("col3_val",   64'(q1_val),   64'h55);
        chk("col3_busy",  64'(busy_cnt), 64'd1);

        // hci_rdy = 0 freezes everything.
        cyc(0, 0, 0, 1, 4, 1, 5, 32'hABCD, 4, 5);
        idle(4, 5);
        chk("frz_busy", 64'(busy_cnt), 64'd1);

        // Writeback bypass (or not) on query port 2.
        cyc(0, 1, 0, 0, 0, 1, 9, 32'h1234, 0, 9);
        idle(0, 9);
        chk("wb9_q2_val", 64'(q2_val), 64'h1234);

        // Fill all entries, re-alloc when full, then flush.
        for (int i = 0; i < 32; i++) cyc(0, 1, 0, 1, 5'(i), 0, 0, 0, 5'(i), 7);
        chk("full_flag", 64'(full),     64'd1);
        chk("full_cnt",  64'(busy_cnt), 64'd32);
        cyc(0, 1, 0, 1, 12, 0, 0, 0, 12, 3);
        chk("full_hold", 64'(busy_cnt), 64'd32);
        cyc(0, 1, 1, 1, 6, 1, 8, 32'hFFFF, 7, 8);
        chk("flush_cnt",  64'(busy_cnt), 64'd0);
        chk("flush_full", 64'(full),     64'd0);
        idle(7, 3);
        chk("flush_val7", 64'(q1_val), 64'hDEADBEEF);

        // Randomized traffic; narrow id range half the time to force collisions.
        for (int n = 0; n < 1500; n++) begin
            logic [4:0] aid, wid, qa, qb;
            bit narrow;
            narrow = ($urandom_range(0, 1) == 1);
            aid = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            wid = narrow ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            qa  = ($urandom_range(0, 2) == 0) ? wid : 5'($urandom_range(0, 31));
            qb  = ($urandom_range(0, 2) == 0) ? aid : 5'($urandom_range(0, 31));
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 6, aid,
                $urandom_range(0, 9) < 4, wid, $urandom, qa, qb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vreg_status_file
`default_nettype wire
